// File: rtl/bresenham_stream.sv
// Streaming Bresenham ray caster: beam FIFO -> SETUP -> per-cell STEP onto a valid/ready cell stream.
// Optional macro BRESENHAM_CLIP_EN: suppress cells outside the grid instead of wrapping their indices.

module bresenham_stream #(
  parameter int INDEX_WIDTH = 8,
  parameter int COORD_WIDTH = INDEX_WIDTH + 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          beam_valid,
  output logic                          beam_ready,
  input  logic signed [COORD_WIDTH-1:0] x0,
  input  logic signed [COORD_WIDTH-1:0] y0,
  input  logic signed [COORD_WIDTH-1:0] x1,
  input  logic signed [COORD_WIDTH-1:0] y1,
  input  logic                          hit,
  output logic                          cell_valid,
  input  logic                          cell_ready,
  output logic [INDEX_WIDTH-1:0]        x_index,
  output logic [INDEX_WIDTH-1:0]        y_index,
  output logic                          cell_is_free,
  output logic                          cell_last,
  output logic                          ray_done,
  output logic                          busy
);

  localparam int EW = COORD_WIDTH + 2;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  typedef logic signed [COORD_WIDTH-1:0] coord_t;
  typedef logic signed [EW-1:0]          wide_t;

  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
    logic   hit;
  } beam_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STEP, ST_DRAIN} state_t;

  function automatic wide_t sext(input coord_t v);
    return wide_t'(v);
  endfunction

  // ---------------------------------------------------------------- beam FIFO
  beam_t         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          push;
  logic          pop;
  state_t        state;
  state_t        state_next;

  assign push = beam_valid && beam_ready;
  assign pop  = (state == ST_IDLE) && (count != '0);

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + (PW+1)'(1);
    else if (!push && pop) count_next = count - (PW+1)'(1);
  end

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= '{x0: x0, y0: y0, x1: x1, y1: y1, hit: hit};
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beam_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      beam_ready <= (count_next != FULL_COUNT);
    end
  end

  assign busy = (count != '0) || (state != ST_IDLE);

  // ---------------------------------------------------------------- ray datapath
  beam_t ray;
  coord_t cx;
  coord_t cy;
  wide_t  dx;
  wide_t  dy;
  wide_t  err;
  logic   sx_neg;
  logic   sy_neg;

  wide_t  diff_x;
  wide_t  diff_y;
  wide_t  abs_x;
  wide_t  abs_y;
  logic signed [EW:0] e2;
  logic   step_x;
  logic   step_y;
  wide_t  err_next;
  coord_t cx_next;
  coord_t cy_next;
  logic   at_end;
  logic   in_grid;
  logic   slot_free;
  logic   done_now;

  assign diff_x = sext(ray.x1) - sext(ray.x0);
  assign diff_y = sext(ray.y1) - sext(ray.y0);
  assign abs_x  = diff_x[EW-1] ? -diff_x : diff_x;
  assign abs_y  = diff_y[EW-1] ? -diff_y : diff_y;

  // The doubled error never overflows one extra bit, so compare in EW+1 bits.
  assign e2       = {err, 1'b0};
  assign step_x   = e2 >= (EW+1)'(dy);
  assign step_y   = e2 <= (EW+1)'(dx);
  assign err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
  assign cx_next  = step_x ? (sx_neg ? cx - coord_t'(1) : cx + coord_t'(1)) : cx;
  assign cy_next  = step_y ? (sy_neg ? cy - coord_t'(1) : cy + coord_t'(1)) : cy;

  assign at_end    = (cx == ray.x1) && (cy == ray.y1);
  assign slot_free = !cell_valid || cell_ready;

`ifdef BRESENHAM_CLIP_EN
  // In-grid means every bit above the index field, sign included, is zero.
  assign in_grid = (cx[COORD_WIDTH-1:INDEX_WIDTH] == '0) &&
                   (cy[COORD_WIDTH-1:INDEX_WIDTH] == '0);
`else
  assign in_grid = 1'b1;
`endif

  assign done_now = ((state == ST_STEP) && slot_free && at_end && !in_grid) ||
                    ((state == ST_DRAIN) && cell_ready);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: next state gets its default first, so no path through the block can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pop) state_next = ST_SETUP;
      ST_SETUP: state_next = ST_STEP;
      ST_STEP:  if (slot_free && at_end) state_next = in_grid ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (cell_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The iterator runs one cell ahead of the output register; the endpoint waits in DRAIN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ray          <= '0;
      cx           <= '0;
      cy           <= '0;
      dx           <= '0;
      dy           <= '0;
      err          <= '0;
      sx_neg       <= 1'b0;
      sy_neg       <= 1'b0;
      cell_valid   <= 1'b0;
      x_index      <= '0;
      y_index      <= '0;
      cell_is_free <= 1'b0;
      cell_last    <= 1'b0;
      ray_done     <= 1'b0;
    end else begin
      ray_done <= done_now;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            ray <= fifo_mem[rd_ptr];
            cx  <= fifo_mem[rd_ptr].x0;
            cy  <= fifo_mem[rd_ptr].y0;
          end
        end
        ST_SETUP: begin
          dx     <= abs_x;
          dy     <= -abs_y;
          err    <= abs_x - abs_y;
          sx_neg <= diff_x[EW-1];
          sy_neg <= diff_y[EW-1];
        end
        ST_STEP: begin
          if (slot_free) begin
            cell_valid   <= in_grid;
            x_index      <= cx[INDEX_WIDTH-1:0];
            y_index      <= cy[INDEX_WIDTH-1:0];
            cell_is_free <= !at_end || !ray.hit;
            cell_last    <= at_end && in_grid;
            if (!at_end) begin
              cx  <= cx_next;
              cy  <= cy_next;
              err <= err_next;
            end
          end
        end
        ST_DRAIN: begin
          if (cell_ready) begin
            cell_valid <= 1'b0;
            cell_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_stream.sv
// Self-checking bench for bresenham_stream: directed test-plan beams plus random beams vs a line-tracing model.
// Honours BRESENHAM_CLIP_EN the same way the design does.

module tb_bresenham_stream;

  localparam int IW = 8;
  localparam int CW = IW + 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                 beam_valid = 1'b0;
  logic                 beam_ready;
  logic signed [CW-1:0] x0 = '0;
  logic signed [CW-1:0] y0 = '0;
  logic signed [CW-1:0] x1 = '0;
  logic signed [CW-1:0] y1 = '0;
  logic                 hit = 1'b0;
  logic                 cell_valid;
  logic                 cell_ready = 1'b0;
  logic [IW-1:0]        x_index;
  logic [IW-1:0]        y_index;
  logic                 cell_is_free;
  logic                 cell_last;
  logic                 ray_done;
  logic                 busy;

  bresenham_stream #(.INDEX_WIDTH(IW), .COORD_WIDTH(CW), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .beam_valid(beam_valid), .beam_ready(beam_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .hit(hit),
    .cell_valid(cell_valid), .cell_ready(cell_ready),
    .x_index(x_index), .y_index(y_index),
    .cell_is_free(cell_is_free), .cell_last(cell_last),
    .ray_done(ray_done), .busy(busy)
  );

  typedef struct packed {
    logic [IW-1:0] x;
    logic [IW-1:0] y;
    logic          free;
    logic          last;
  } cell_t;

  cell_t exp_q[$];
  cell_t got_q[$];
  cell_t lit[$];
  cell_t mq[$];
  bit    mq_end_vis;
  bit    ray_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;   // 0 hold, 1 toggle, 2 random
  int push_edge = 0;
  int rise_cyc  = 0;
  int done_cnt  = 0;

  cell_t cur;
  assign cur = {x_index, y_index, cell_is_free, cell_last};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cell_t mk(input int x, input int y, input bit f, input bit l);
    cell_t c;
    c.x = IW'(x);
    c.y = IW'(y);
    c.free = f;
    c.last = l;
    return c;
  endfunction

  function automatic bit on_grid(input int v);
    return (v >= 0) && (v < (1 << IW));
  endfunction

  // Reference: trace the line cell by cell with integer arithmetic, then apply the visibility rule.
  function automatic void model_ray(input int ax0, input int ay0, input int ax1, input int ay1, input bit h);
    int dx, dy, sx, sy, err, e2, x, y;
    bit at_end, vis;
    mq.delete();
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy;
    x = ax0;
    y = ay0;
    for (int i = 0; i < 4096; i++) begin
      at_end = (x == ax1) && (y == ay1);
`ifdef BRESENHAM_CLIP_EN
      vis = on_grid(x) && on_grid(y);
`else
      vis = 1'b1;
`endif
      if (vis) mq.push_back(mk(x, y, !at_end || !h, at_end));
      if (at_end) begin
        mq_end_vis = vis;
        break;
      end
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      1: cell_ready = ~cell_ready;
      2: cell_ready = ($urandom_range(0, 9) < 7);
      default: ;
    endcase
  end

  // Compare process: values seen at the falling edge are what the next rising edge will sample.
  bit    prev_stall = 0;
  bit    prev_last_acc = 0;
  bit    prev_valid = 0;
  cell_t prev_cell;
  bit    end_vis;

  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      ray_q.delete();
      prev_stall = 0;
      prev_last_acc = 0;
      prev_valid = 0;
    end else begin
      if (beam_valid && beam_ready) begin
        model_ray(int'(x0), int'(y0), int'(x1), int'(y1), hit);
        foreach (mq[i]) exp_q.push_back(mq[i]);
        ray_q.push_back(mq_end_vis);
        push_edge = cyc + 1;
      end
      if (prev_stall) begin
        check("stall_valid", cell_valid, 1);
        check("stall_hold", cur, prev_cell);
      end
      if (cell_valid && !prev_valid) rise_cyc = cyc;
      if (prev_last_acc) check("ray_done_pulse", ray_done, 1);
      if (ray_done) begin
        done_cnt++;
        if (ray_q.size() == 0) check("ray_done_spurious", ray_done, 0);
        else begin
          end_vis = ray_q.pop_front();
          if (end_vis) check("ray_done_timing", prev_last_acc, 1);
        end
      end
      if (cell_valid && cell_ready) begin
        if (exp_q.size() == 0) check("cell_unexpected", cell_valid, 0);
        else check("cell", cur, exp_q.pop_front());
        got_q.push_back(cur);
      end
      prev_stall    = cell_valid && !cell_ready;
      prev_last_acc = cell_valid && cell_ready && cell_last;
      prev_valid    = cell_valid;
      prev_cell     = cur;
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beam(input int ax0, input int ay0, input int ax1, input int ay1, input bit h);
    bit ok = 0;
    x0 = CW'(ax0);
    y0 = CW'(ay0);
    x1 = CW'(ax1);
    y1 = CW'(ay1);
    hit = h;
    beam_valid = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (beam_ready) begin
        ok = 1;
        break;
      end
    end
    check("beam_accept", ok, 1);
    @(posedge clock);
    #1;
    beam_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clock);
      if (!busy && !beam_valid && exp_q.size() == 0 && ray_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("idle_reached", ok, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic cmp_got(input string name);
    check({name, "_count"}, got_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < got_q.size(); i++) check(name, got_q[i], lit[i]);
  endtask

  int bx0, by0, bx1, by1, lo, hi, done_before;

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #3;
    check("rst_cell_valid", cell_valid, 0);
    check("rst_beam_ready", beam_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_outputs", {ray_done, cell_last, cell_is_free, x_index, y_index}, 0);

    // Pin the model against hand-traced lines
    model_ray(5, 5, 2, 3, 0);
    check("pin_neg_count", mq.size(), 4);
    check("pin_neg_1", mq[1], mk(4, 4, 1, 0));
    check("pin_neg_2", mq[2], mk(3, 4, 1, 0));
    check("pin_neg_3", mq[3], mk(2, 3, 1, 1));
    model_ray(0, 0, 0, 4, 1);
    check("pin_vert_count", mq.size(), 5);
    check("pin_vert_4", mq[4], mk(0, 4, 0, 1));

    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1 check("ready_before_edge", beam_ready, 0);
    @(posedge clock);
    #1 check("ready_after_edge", beam_ready, 1);

    // (0,0)->(3,0), hit, ready held high
    ready_mode = 0;
    cell_ready = 1'b1;
    got_q.delete();
    send_beam(0, 0, 3, 0, 1);
    wait_idle();
    lit.delete();
    lit.push_back(mk(0, 0, 1, 0));
    lit.push_back(mk(1, 0, 1, 0));
    lit.push_back(mk(2, 0, 1, 0));
    lit.push_back(mk(3, 0, 0, 1));
    cmp_got("line_x");
    check("latency", rise_cyc - push_edge, 3);

    // Negative octant
    got_q.delete();
    send_beam(5, 5, 2, 3, 0);
    wait_idle();
    lit.delete();
    lit.push_back(mk(5, 5, 1, 0));
    lit.push_back(mk(4, 4, 1, 0));
    lit.push_back(mk(3, 4, 1, 0));
    lit.push_back(mk(2, 3, 1, 1));
    cmp_got("neg_octant");

    // Degenerate ray
    got_q.delete();
    send_beam(7, 7, 7, 7, 1);
    wait_idle();
    lit.delete();
    lit.push_back(mk(7, 7, 0, 1));
    cmp_got("degenerate");

    // Toggling ready
    ready_mode = 1;
    got_q.delete();
    send_beam(0, 0, 0, 4, 0);
    wait_idle();
    lit.delete();
    for (int i = 0; i < 5; i++) lit.push_back(mk(0, i, 1, i == 4));
    cmp_got("toggle_ready");

    // Grid edge: clipped or wrapped
    ready_mode = 0;
    cell_ready = 1'b1;
    got_q.delete();
    send_beam(-2, 0, 2, 0, 1);
    wait_idle();
    lit.delete();
`ifndef BRESENHAM_CLIP_EN
    lit.push_back(mk(254, 0, 1, 0));
    lit.push_back(mk(255, 0, 1, 0));
`endif
    lit.push_back(mk(0, 0, 1, 0));
    lit.push_back(mk(1, 0, 1, 0));
    lit.push_back(mk(2, 0, 0, 1));
    cmp_got("grid_edge");

    // FIFO full: one ray stalled in the engine, four queued, fifth held
    cell_ready = 1'b0;
    send_beam(0, 0, 2, 0, 0);
    repeat (4) @(posedge clock);
    #1;
    send_beam(10, 10, 12, 11, 1);
    send_beam(20, 5, 18, 5, 0);
    send_beam(3, 3, 3, 3, 1);
    send_beam(100, 50, 96, 52, 1);
    @(negedge clock);
    check("full_ready_low", beam_ready, 0);
    check("full_busy", busy, 1);
    @(posedge clock);
    #1;
    beam_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("fifth_held", beam_ready, 0);
    end
    @(posedge clock);
    #1;
    done_before = done_cnt;
    cell_ready = 1'b1;
    send_beam(30, 30, 33, 27, 0);
    check("fifth_after_pop", done_cnt > done_before, 1);
    wait_idle();

    // Random beams under random back-pressure
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       begin lo = 0;    hi = 15;  end
        1:       begin lo = -8;   hi = 263; end
        default: begin lo = -100; hi = 350; end
      endcase
      bx0 = lo + int'($urandom_range(0, hi - lo));
      by0 = lo + int'($urandom_range(0, hi - lo));
      bx1 = lo + int'($urandom_range(0, hi - lo));
      by1 = lo + int'($urandom_range(0, hi - lo));
      if ($urandom_range(0, 7) == 0) begin bx1 = bx0; by1 = by0; end
      send_beam(bx0, by0, bx1, by1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    wait_idle();

    // Reset mid-ray
    ready_mode = 0;
    cell_ready = 1'b1;
    send_beam(0, 0, 0, 30, 1);
    repeat (8) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_cell_valid", cell_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_beam_ready", beam_ready, 0);
    check("midrst_outputs", {ray_done, cell_last, cell_is_free, x_index, y_index}, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 check("midrst_ready_back", beam_ready, 1);
    got_q.delete();
    send_beam(9, 1, 11, 2, 1);
    wait_idle();
    lit.delete();
    lit.push_back(mk(9, 1, 1, 0));
    lit.push_back(mk(10, 2, 1, 0));
    lit.push_back(mk(11, 2, 0, 1));
    cmp_got("after_reset");

    check("final_busy", busy, 0);
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
